btn_conditioner: RTL and testbench

- Input-conditioning stage directly upstream of the calculator top level.
- Takes the five raw, asynchronous, bouncing push-buttons (btnc, btnl, btnr, btnu, btnd) and produces clean, clock-synchronous signals.
- Each button gets a two-flop synchronizer and a counter-based debounce state machine.
- Outputs are a stable debounced level plus a single-cycle rising-edge pulse per button. The accumulator load and clear, and the op-select lines, consume these instead of raw pins.

---
 rtl/btn_conditioner.sv | 113 +++++++++++
 tb/tb_btn_conditioner.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Push-button conditioner: two-flop synchronizer plus counter-based debounce FSM
// per button, producing a stable level and single-cycle press/release pulses.
module btn_conditioner #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             busy
);

  localparam logic [1:0] ST_LOW       = 2'd0;
  localparam logic [1:0] ST_WAIT_HIGH = 2'd1;
  localparam logic [1:0] ST_HIGH      = 2'd2;
  localparam logic [1:0] ST_WAIT_LOW  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;

  // Per-button state is kept in a named array so checkers can bind to it.
  logic [1:0]       fsm_state [N_BTN];
  logic [1:0]       state_d   [N_BTN];
  logic [CNT_W-1:0] cnt       [N_BTN];
  logic [CNT_W-1:0] cnt_d     [N_BTN];
  logic [N_BTN-1:0] level_d;
  logic [N_BTN-1:0] press_d;
  logic [N_BTN-1:0] release_d;
  logic [N_BTN-1:0] wait_d;

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i]   = fsm_state[i];
      cnt_d[i]     = cnt[i];
      press_d[i]   = 1'b0;
      release_d[i] = 1'b0;
      case (fsm_state[i])
        ST_LOW: begin
          if (sync2[i]) begin
            state_d[i] = ST_WAIT_HIGH;
            cnt_d[i]   = '0;
          end
        end
        ST_WAIT_HIGH: begin
          if (!sync2[i]) begin
            state_d[i] = ST_LOW;
            cnt_d[i]   = '0;
          end else if (cnt[i] == CNT_LAST) begin
            state_d[i] = ST_HIGH;
            cnt_d[i]   = '0;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt[i] + CNT_W'(1);
          end
        end
        ST_HIGH: begin
          if (!sync2[i]) begin
            state_d[i] = ST_WAIT_LOW;
            cnt_d[i]   = '0;
          end
        end
        default: begin
          if (sync2[i]) begin
            state_d[i] = ST_HIGH;
            cnt_d[i]   = '0;
          end else if (cnt[i] == CNT_LAST) begin
            state_d[i]   = ST_LOW;
            cnt_d[i]     = '0;
            release_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt[i] + CNT_W'(1);
          end
        end
      endcase
      // Outputs are decoded from the next state so they register on the transition edge.
      level_d[i] = (state_d[i] == ST_HIGH) || (state_d[i] == ST_WAIT_LOW);
      wait_d[i]  = (state_d[i] == ST_WAIT_HIGH) || (state_d[i] == ST_WAIT_LOW);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1       <= '0;
      sync2       <= '0;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      busy        <= 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        fsm_state[i] <= ST_LOW;
        cnt[i]       <= '0;
      end
    end else begin
      sync1       <= btn_raw;
      sync2       <= sync1;
      btn_level   <= level_d;
      btn_press   <= press_d;
      btn_release <= release_d;
      busy        <= |wait_d;
      for (int i = 0; i < N_BTN; i++) begin
        fsm_state[i] <= state_d[i];
        cnt[i]       <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner with a short debounce window; pulses are matched
// against an expected queue of {cycle, press, release} words.
module tb_btn_conditioner;

  localparam int N_BTN = 5;
  localparam int DEB   = 4;
  localparam int CNT_W = 3;
  localparam int W     = 16 + 2 * N_BTN;
  localparam int LAT   = DEB + 3;

  logic             clk = 1'b0;
  logic             resetn;
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic             busy;

  int unsigned      cyc = 0;
  int               checks = 0;
  int               errors = 0;
  int               press_seen = 0;
  int               release_seen = 0;
  logic [W-1:0]     exp_q[$];

  btn_conditioner #(.N_BTN(N_BTN), .DEBOUNCE_CYCLES(DEB), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .btn_raw(btn_raw), .btn_level(btn_level),
    .btn_press(btn_press), .btn_release(btn_release), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Advance one cycle; any pulse seen at the negedge is matched against the queue head.
  task automatic tick();
    logic [W-1:0] got;
    logic [W-1:0] exp;
    @(negedge clk);
    if (btn_press[0]) press_seen++;
    if (btn_release != '0) release_seen++;
    if ((btn_press | btn_release) != '0) begin
      checks++;
      got = {cyc[15:0], btn_press, btn_release};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got cycle=%0d press=%b release=%b, required no pulse",
                 cyc, btn_press, btn_release);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL pulse: got cycle=%0d press=%b release=%b, required cycle=%0d press=%b release=%b",
                   got[W-1:2*N_BTN], got[2*N_BTN-1:N_BTN], got[N_BTN-1:0],
                   exp[W-1:2*N_BTN], exp[2*N_BTN-1:N_BTN], exp[N_BTN-1:0]);
        end
      end
    end
  endtask

  task automatic expect_pulse(input int unsigned at, input logic [N_BTN-1:0] p,
                              input logic [N_BTN-1:0] r);
    logic [15:0] c16;
    c16 = 16'(at);
    exp_q.push_back({c16, p, r});
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pulses still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    resetn  = 1'b0;
    btn_raw = 5'h1F;
    repeat (3) tick();
    checks++;
    if ({btn_level, btn_press, btn_release, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got level=%b press=%b release=%b busy=%b, required all 0",
               btn_level, btn_press, btn_release, busy);
    end
    resetn = 1'b1;
    expect_pulse(cyc + LAT, 5'h1F, 5'h00);
    repeat (3) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy: got %b, required 1", busy);
    end
    drain("reset_press", 20);
    tick();
    checks++;
    if (btn_level !== 5'h1F || btn_press !== 5'h00) begin
      errors++;
      $display("FAIL reset_level: got level=%b press=%b, required 11111 00000", btn_level, btn_press);
    end
    btn_raw = 5'h00;
    expect_pulse(cyc + LAT, 5'h00, 5'h1F);
    drain("reset_release", 20);
    tick();
    checks++;
    if (btn_level !== 5'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got level=%b busy=%b, required 00000 0", btn_level, busy);
    end
  endtask

  task automatic test_clean_press();
    btn_raw = 5'h10;
    expect_pulse(cyc + LAT, 5'h10, 5'h00);
    repeat (20) tick();
    drain("clean_press", 5);
    checks++;
    if (btn_level !== 5'h10) begin
      errors++;
      $display("FAIL clean_level_high: got %b, required 10000", btn_level);
    end
    btn_raw = 5'h00;
    expect_pulse(cyc + LAT, 5'h00, 5'h10);
    repeat (12) tick();
    drain("clean_release", 5);
    checks++;
    if (btn_level !== 5'h00) begin
      errors++;
      $display("FAIL clean_level_low: got %b, required 00000", btn_level);
    end
  endtask

  task automatic test_bounce();
    logic [5:0] pat;
    int unsigned last_rise;
    pat = 6'b101101;
    last_rise = 0;
    for (int i = 5; i >= 0; i--) begin
      btn_raw = {4'b0000, pat[i]};
      if (pat[i]) last_rise = cyc;
      tick();
    end
    expect_pulse(last_rise + LAT, 5'h01, 5'h00);
    drain("bounce_press", 20);
    repeat (3) tick();
    btn_raw = 5'h00;
    expect_pulse(cyc + LAT, 5'h00, 5'h01);
    drain("bounce_release", 20);
    btn_raw = 5'h01;
    repeat (3) tick();
    btn_raw = 5'h00;
    repeat (10) tick();
    checks++;
    if (btn_level !== 5'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_reject: got level=%b busy=%b, required 00000 0", btn_level, busy);
    end
  endtask

  task automatic test_simultaneous();
    logic exp_busy;
    btn_raw = 5'b00110;
    expect_pulse(cyc + LAT, 5'b00110, 5'h00);
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_busy = (k >= 3 && k <= LAT - 1);
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL simul_busy_edge%0d: got %b, required %b", k, busy, exp_busy);
      end
    end
    drain("simul_press", 5);
    btn_raw = 5'h00;
    expect_pulse(cyc + LAT, 5'h00, 5'b00110);
    drain("simul_release", 20);
  endtask

  task automatic test_reset_mid();
    btn_raw = 5'h08;
    repeat (4) tick();
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy_before: got %b, required 1", busy);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({btn_level, btn_press, btn_release, busy} !== '0) begin
      errors++;
      $display("FAIL mid_reset_clear: got level=%b press=%b busy=%b, required all 0",
               btn_level, btn_press, busy);
    end
    tick();
    btn_raw = 5'h00;
    repeat (3) tick();
    resetn = 1'b1;
    repeat (15) tick();
    checks++;
    if ({btn_level, btn_press, btn_release, busy} !== '0) begin
      errors++;
      $display("FAIL mid_after_release: got level=%b busy=%b, required all 0", btn_level, busy);
    end
  endtask

  task automatic test_long_hold();
    int p0;
    int r0;
    p0 = press_seen;
    r0 = release_seen;
    btn_raw = 5'h01;
    expect_pulse(cyc + LAT, 5'h01, 5'h00);
    repeat (1000) tick();
    checks++;
    if (press_seen - p0 != 1 || release_seen - r0 != 0) begin
      errors++;
      $display("FAIL long_hold: got press=%0d release=%0d, required 1 0",
               press_seen - p0, release_seen - r0);
    end
    drain("long_press", 5);
    btn_raw = 5'h00;
    expect_pulse(cyc + LAT, 5'h00, 5'h01);
    drain("long_release", 20);
  endtask

  task automatic test_random_levels();
    logic [N_BTN-1:0] cur;
    logic [N_BTN-1:0] nxt;
    cur = 5'h00;
    for (int n = 0; n < 6; n++) begin
      nxt = N_BTN'($urandom_range(0, 31));
      btn_raw = nxt;
      if (nxt != cur) expect_pulse(cyc + LAT, nxt & ~cur, cur & ~nxt);
      repeat (LAT + 3) tick();
      drain("random_step", 5);
      checks++;
      if (btn_level !== nxt) begin
        errors++;
        $display("FAIL random_level: got %b, required %b", btn_level, nxt);
      end
      cur = nxt;
    end
    btn_raw = 5'h00;
    if (cur != 5'h00) expect_pulse(cyc + LAT, 5'h00, cur);
    drain("random_final", 20);
    repeat (4) tick();
  endtask

  initial begin
    resetn  = 1'b0;
    btn_raw = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_long_hold();
    test_random_levels();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
